// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter in front of one TCDM bank, with a fixed-latency response-routing pipeline.
// Optional macro TCDM_ARB_PRIO_EN adds ini_prio_i; priority requesters beat normal ones.
module tcdm_bank_arbiter #(
  parameter int unsigned NbIni     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned Latency   = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NbIni-1:0]                   ini_req_i,
  output logic [NbIni-1:0]                   ini_gnt_o,
  input  logic [NbIni-1:0][AddrWidth-1:0]    ini_add_i,
  input  logic [NbIni-1:0]                   ini_wen_i,
  input  logic [NbIni-1:0][DataWidth-1:0]    ini_data_i,
  input  logic [NbIni-1:0][BeWidth-1:0]      ini_be_i,
  input  logic [NbIni-1:0][IdWidth-1:0]      ini_id_i,
`ifdef TCDM_ARB_PRIO_EN
  input  logic [NbIni-1:0]                   ini_prio_i,
`endif
  output logic [NbIni-1:0]                   ini_r_valid_o,
  output logic [DataWidth-1:0]               ini_r_data_o,
  output logic [IdWidth-1:0]                 ini_r_id_o,
  output logic                               bank_req_o,
  input  logic                               bank_gnt_i,
  output logic [AddrWidth-1:0]               bank_add_o,
  output logic                               bank_wen_o,
  output logic [DataWidth-1:0]               bank_data_o,
  output logic [BeWidth-1:0]                 bank_be_o,
  output logic [IdWidth-1:0]                 bank_id_o,
  input  logic [DataWidth-1:0]               bank_r_data_i,
  input  logic [IdWidth-1:0]                 bank_r_id_i
);

  localparam int unsigned IdxW = (NbIni > 1) ? $clog2(NbIni) : 1;

  logic [IdxW-1:0]              rr_q;
  logic [IdxW-1:0]              winner;
  logic [NbIni-1:0]             eligible;
  logic                         found;
  int unsigned                  scan_idx;
  logic                         handshake;
  logic [Latency-1:0]           pipe_vld_q;
  logic [Latency-1:0][IdxW-1:0] pipe_idx_q;

`ifdef TCDM_ARB_PRIO_EN
  // Only the high-priority class competes when any of its members is requesting.
  always_comb begin
    eligible = ini_req_i;
    if (|(ini_req_i & ini_prio_i)) eligible = ini_req_i & ini_prio_i;
  end
`else
  assign eligible = ini_req_i;
`endif

  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NbIni; k++) begin
      scan_idx = (32'(rr_q) + k) % NbIni;
      if (!found && eligible[IdxW'(scan_idx)]) begin
        winner = IdxW'(scan_idx);
        found  = 1'b1;
      end
    end
  end

  assign bank_req_o  = |ini_req_i;
  assign handshake   = bank_req_o & bank_gnt_i;
  assign bank_add_o  = ini_add_i[winner];
  assign bank_wen_o  = ini_wen_i[winner];
  assign bank_data_o = ini_data_i[winner];
  assign bank_be_o   = ini_be_i[winner];
  assign bank_id_o   = ini_id_i[winner];

  always_comb begin
    ini_gnt_o         = '0;
    ini_gnt_o[winner] = handshake;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
    end else begin
      if (handshake) rr_q <= (winner == IdxW'(NbIni - 1)) ? '0 : winner + 1'b1;
      pipe_vld_q[0] <= handshake;
      pipe_idx_q[0] <= winner;
      for (int unsigned i = 1; i < Latency; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  always_comb begin
    ini_r_valid_o = '0;
    if (pipe_vld_q[Latency-1]) ini_r_valid_o[pipe_idx_q[Latency-1]] = 1'b1;
  end

  assign ini_r_data_o = bank_r_data_i;
  assign ini_r_id_o   = bank_r_id_i;

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Sits directly upstream of one TCDM SRAM bank and multiplexes NbIni initiator ports onto that single bank port.
- Arbitrates round-robin among the initiators.
- Tracks which initiator won each accepted request and returns the bank read data plus a response-valid strobe to that initiator after the bank's fixed read latency.
- One instance per bank, between the cluster interconnect and the bank array.

Parameters:
- NbIni, 4, number of initiator ports (>=1)
- DataWidth, 32, data width
- AddrWidth, 32, address width
- BeWidth, DataWidth/8, byte-enable width
- IdWidth, 1, transaction id width
- Latency, 1, bank read latency in cycles (>=1), must match the bank

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- ini_req_i  input  NbIni  per-initiator request
- ini_gnt_o  output  NbIni  per-initiator grant
- ini_add_i  input  NbIni x AddrWidth  request address
- ini_wen_i  input  NbIni  1 = read, 0 = write
- ini_data_i  input  NbIni x DataWidth  write data
- ini_be_i  input  NbIni x BeWidth  byte enables
- ini_id_i  input  NbIni x IdWidth  transaction id
- ini_r_valid_o  output  NbIni  one-hot response strobe
- ini_r_data_o  output  DataWidth  response data, broadcast to all initiators
- ini_r_id_o  output  IdWidth  response id, broadcast to all initiators
- bank_req_o  output  1  bank request
- bank_gnt_i  input  1  bank grant
- bank_add_o  output  AddrWidth  bank address
- bank_wen_o  output  1  bank read/write
- bank_data_o  output  DataWidth  bank write data
- bank_be_o  output  BeWidth  bank byte enables
- bank_id_o  output  IdWidth  bank id
- bank_r_data_i  input  DataWidth  bank read data
- bank_r_id_i  input  IdWidth  bank response id

Behaviour:
- Clock clk_i; reset rst_ni, asynchronous, active-low.
- IdxW = max(1, $clog2(NbIni)).
- State:
  - round-robin pointer rr_q[IdxW]
  - response pipeline of Latency stages, each {valid, idx[IdxW]}
- Arbitration (combinational):
  - winner = first requesting index scanning rr_q, rr_q+1, ... wrapping modulo NbIni.
  - bank_req_o = |ini_req_i.
  - Bank request fields are muxed from the winner.
  - ini_gnt_o[winner] = bank_gnt_i; all other grant bits 0.
  - No grant to any initiator while bank_gnt_i = 0.
- Handshake = bank_req_o & bank_gnt_i.
  - On handshake, rr_q <= winner+1, wrapping to 0 when winner = NbIni-1.
  - Otherwise rr_q holds.
- Response pipeline:
  - Stage 0 captures {handshake, winner}; later stages shift by one each cycle.
  - The final stage drives ini_r_valid_o: a one-hot at its idx when valid, else all zero.
  - A response is produced for both reads and writes, exactly Latency cycles after the handshake.
- ini_r_data_o = bank_r_data_i and ini_r_id_o = bank_r_id_i, passed through combinationally.
  - Data is meaningful only for reads; write response data is don't-care.
- Back-to-back handshakes every cycle are supported; throughput is one request per cycle.
- Single requester: it wins every cycle regardless of rr_q.
- Requests may be withdrawn before grant; no lock is held.
- NbIni = 1: rr_q is constant 0; the block degenerates to a pass-through plus the valid pipeline.
- Reset values:
  - rr_q = 0, all pipeline valids = 0.
  - ini_r_valid_o = 0.
  - ini_gnt_o and bank_req_o follow the inputs combinationally.
- Reset mid-operation: in-flight responses are discarded and no r_valid is emitted after reset release. Initiators must not expect them.

Optional Feature:
- Macro: TCDM_ARB_PRIO_EN.
- Defined:
  - Adds input port ini_prio_i[NbIni].
  - Requesters with prio = 1 win over prio = 0 requesters.
  - Round-robin from rr_q applies within the winning class.
  - rr_q updates to winner+1 as usual.
- Undefined:
  - Port is absent; pure round-robin.

Test Plan:
- Reset then idle: rr_q = 0, ini_r_valid_o = 0, bank_req_o = 0 for 10 cycles.
- Initiators 0–3 all request reads continuously with bank_gnt_i = 1. Required:
  - grants in order 0,1,2,3,0 on consecutive cycles
  - ini_r_valid_o = 0001, 0010, 0100, 1000 each delayed Latency = 1 cycle
  - ini_r_data_o equals the bank data for each address
- Write then read: init 2 writes 0xDEADBEEF with be = 0xF to address 0x10; init 1 then reads 0x10. Required:
  - ini_r_valid_o[2] one cycle after the write
  - ini_r_data_o = 0xDEADBEEF with ini_r_valid_o[1]
- bank_gnt_i = 0 for 3 cycles with initiators 1 and 3 requesting: ini_gnt_o = 0, rr_q unchanged. On gnt high, init 1 wins first, then init 3.
- Reset asserted one cycle after a handshake with Latency = 2: no ini_r_valid_o pulse after release; rr_q = 0.
- With TCDM_ARB_PRIO_EN: init 0 and init 3 request, ini_prio_i = 1000, rr_q = 0. Required: init 3 granted, then init 0 once init 3 drops its request.
